// File: rtl/commit_trace_fifo_pkg.sv
// Shared encodings and record layout for the commit trace FIFO.
// A record is {kind, pc, addr, data, byteen} = 101 bits.
package commit_trace_fifo_pkg;

  typedef enum logic {
    KIND_GRF   = 1'b0,
    KIND_STORE = 1'b1
  } rec_kind_e;

  localparam int PC_W     = 32;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int BYTEEN_W = 4;
  localparam int REG_W    = 5;
  localparam int REC_W    = 1 + PC_W + ADDR_W + DATA_W + BYTEEN_W;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_CNTW  = 16;

  typedef struct packed {
    rec_kind_e             kind;
    logic [PC_W-1:0]       pc;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     data;
    logic [BYTEEN_W-1:0]   byteen;
  } trace_rec_t;

endpackage

// File: rtl/trace_ram.sv
// Trace record storage: two write ports, one asynchronous read port, no reset.
module trace_ram
  import commit_trace_fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we0,
  input  logic [AW-1:0] i_waddr0,
  input  trace_rec_t    i_wdata0,
  input  logic          i_we1,
  input  logic [AW-1:0] i_waddr1,
  input  trace_rec_t    i_wdata1,
  input  logic [AW-1:0] i_raddr,
  output trace_rec_t    o_rdata
);

  trace_rec_t r_mem [DEPTH];

  // The two ports always target consecutive slots, so they never collide.
  always_ff @(posedge clk) begin
    if (i_we0) r_mem[i_waddr0] <= i_wdata0;
    if (i_we1) r_mem[i_waddr1] <= i_wdata1;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/commit_trace_fifo.sv
// Captures GRF writebacks and stores into a trace FIFO, dropping and counting
// events that do not fit.
module commit_trace_fifo
  import commit_trace_fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNTW  = DEFAULT_CNTW,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                w_grf_we,
  input  logic [REG_W-1:0]    w_grf_addr,
  input  logic [DATA_W-1:0]   w_grf_wdata,
  input  logic [PC_W-1:0]     w_inst_addr,
  input  logic [BYTEEN_W-1:0] m_data_byteen,
  input  logic [ADDR_W-1:0]   m_data_addr,
  input  logic [DATA_W-1:0]   m_data_wdata,
  input  logic [PC_W-1:0]     m_inst_addr,
  input  logic                clr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_kind,
  output logic [PC_W-1:0]     out_pc,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [DATA_W-1:0]   out_data,
  output logic [BYTEEN_W-1:0] out_byteen,
  output logic [LW-1:0]       level,
  output logic                overflow,
  output logic [CNTW-1:0]     drop_cnt
);

  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [LW-1:0]   r_level;
  logic            r_overflow;
  logic [CNTW-1:0] r_dropCnt;

  logic            w_grfEv;
  logic            w_stEv;
  logic            w_pop;
  logic [LW-1:0]   w_free;
  logic [1:0]      w_numEv;
  logic [1:0]      w_nPush;
  logic [1:0]      w_nDrop;
  logic [CNTW:0]   w_dropSum;
  logic [CNTW-1:0] w_dropNext;
  trace_rec_t      w_grfRec;
  trace_rec_t      w_stRec;
  trace_rec_t      w_rec0;
  trace_rec_t      w_head;

  assign w_grfEv = w_grf_we && (w_grf_addr != '0);
  assign w_stEv  = (m_data_byteen != '0);
  assign w_pop   = (r_level != '0) && out_ready;
  assign w_free  = LW'(DEPTH) - r_level + LW'(w_pop);

  assign w_grfRec = '{kind: KIND_GRF, pc: w_inst_addr, addr: {27'b0, w_grf_addr},
                      data: w_grf_wdata, byteen: 4'b0000};
  assign w_stRec  = '{kind: KIND_STORE, pc: m_inst_addr, addr: m_data_addr,
                      data: m_data_wdata, byteen: m_data_byteen};
  assign w_rec0   = w_grfEv ? w_grfRec : w_stRec;

  // With room for only one, the older GRF record wins and the store is dropped.
  always_comb begin
    w_numEv = {1'b0, w_grfEv} + {1'b0, w_stEv};
    w_nPush = 2'd0;
    if (w_free >= LW'(2)) begin
      w_nPush = w_numEv;
    end else if (w_free == LW'(1)) begin
      w_nPush = (w_numEv != 2'd0) ? 2'd1 : 2'd0;
    end
    w_nDrop = w_numEv - w_nPush;
  end

  assign w_dropSum  = {1'b0, r_dropCnt} + (CNTW+1)'(w_nDrop);
  assign w_dropNext = w_dropSum[CNTW] ? '1 : w_dropSum[CNTW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_dropCnt  <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(w_nPush);
      r_rptr  <= r_rptr + AW'(w_pop);
      r_level <= r_level + LW'(w_nPush) - LW'(w_pop);
      // Drops in the clearing cycle still count, so nothing is lost silently.
      if (clr) begin
        r_dropCnt  <= CNTW'(w_nDrop);
        r_overflow <= (w_nDrop != 2'd0);
      end else begin
        r_dropCnt  <= w_dropNext;
        r_overflow <= r_overflow || (w_nDrop != 2'd0);
      end
    end
  end

  trace_ram #(.DEPTH(DEPTH)) u_trace_ram (
    .clk      (clk),
    .i_we0    (w_nPush != 2'd0),
    .i_waddr0 (r_wptr),
    .i_wdata0 (w_rec0),
    .i_we1    (w_nPush == 2'd2),
    .i_waddr1 (r_wptr + AW'(1)),
    .i_wdata1 (w_stRec),
    .i_raddr  (r_rptr),
    .o_rdata  (w_head)
  );

  assign out_valid  = (r_level != '0);
  assign out_kind   = w_head.kind;
  assign out_pc     = w_head.pc;
  assign out_addr   = w_head.addr;
  assign out_data   = w_head.data;
  assign out_byteen = w_head.byteen;
  assign level      = r_level;
  assign overflow   = r_overflow;
  assign drop_cnt   = r_dropCnt;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Randomized scoreboard bench for commit_trace_fifo against a queue-based
// reference model of the trace FIFO.
module tb_commit_trace_fifo;

  localparam int DEPTH   = 16;
  localparam int TB_CNTW = 4;
  localparam int DROPMAX = (1 << TB_CNTW) - 1;

  typedef struct {
    bit        kind;
    bit [31:0] pc;
    bit [31:0] addr;
    bit [31:0] data;
    bit [3:0]  byteen;
  } rec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              grfWe;
  logic [4:0]        grfAddr;
  logic [31:0]       grfData;
  logic [31:0]       grfPc;
  logic [3:0]        memBe;
  logic [31:0]       memAddr;
  logic [31:0]       memData;
  logic [31:0]       memPc;
  logic              clrIn;
  logic              outReady;
  logic              outValid;
  logic              outKind;
  logic [31:0]       outPc;
  logic [31:0]       outAddr;
  logic [31:0]       outData;
  logic [3:0]        outByteen;
  logic [4:0]        level;
  logic              overflow;
  logic [TB_CNTW-1:0] dropCnt;

  rec_t expQ[$];
  int   modelDrop;
  bit   modelOvf;
  bit   monEn;
  int   checks;
  int   failures;

  commit_trace_fifo #(.DEPTH(DEPTH), .CNTW(TB_CNTW)) dut (
    .clk           (clk),
    .reset         (reset),
    .w_grf_we      (grfWe),
    .w_grf_addr    (grfAddr),
    .w_grf_wdata   (grfData),
    .w_inst_addr   (grfPc),
    .m_data_byteen (memBe),
    .m_data_addr   (memAddr),
    .m_data_wdata  (memData),
    .m_inst_addr   (memPc),
    .clr           (clrIn),
    .out_valid     (outValid),
    .out_ready     (outReady),
    .out_kind      (outKind),
    .out_pc        (outPc),
    .out_addr      (outAddr),
    .out_data      (outData),
    .out_byteen    (outByteen),
    .level         (level),
    .overflow      (overflow),
    .drop_cnt      (dropCnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic idleInputs();
    grfWe = 0; grfAddr = 0; grfData = 0; grfPc = 0;
    memBe = 0; memAddr = 0; memData = 0; memPc = 0;
    clrIn = 0; outReady = 0;
  endtask

  // Entered and left one time unit after a rising edge: drives one cycle of
  // inputs, then applies the reference model's view of that edge.
  task automatic applyStimulus(input bit we, input bit [4:0] ga, input bit [31:0] gd,
                               input bit [31:0] gpc, input bit [3:0] be,
                               input bit [31:0] ma, input bit [31:0] md,
                               input bit [31:0] mpc, input bit rdy, input bit clr);
    rec_t evs[$];
    int   dropped;
    #1;
    grfWe = we; grfAddr = ga; grfData = gd; grfPc = gpc;
    memBe = be; memAddr = ma; memData = md; memPc = mpc;
    outReady = rdy; clrIn = clr;
    @(posedge clk);
    #1;
    if (!reset) begin
      if (we && ga != 0) evs.push_back('{0, gpc, {27'b0, ga}, gd, 4'b0000});
      if (be != 0) evs.push_back('{1, mpc, ma, md, be});
      dropped = 0;
      foreach (evs[i]) begin
        if (expQ.size() < DEPTH) expQ.push_back(evs[i]);
        else dropped++;
      end
      if (clr) begin
        modelDrop = dropped;
        modelOvf  = (dropped > 0);
      end else begin
        modelDrop = (modelDrop + dropped > DROPMAX) ? DROPMAX : modelDrop + dropped;
        modelOvf  = modelOvf || (dropped > 0);
      end
    end
  endtask

  task automatic grfEvent(input bit [4:0] ga, input bit [31:0] gd, input bit rdy);
    applyStimulus(1, ga, gd, 32'h3000 + {27'b0, ga}, 0, 0, 0, 0, rdy, 0);
  endtask

  task automatic dualEvent(input bit [4:0] ga, input bit rdy, input bit clr);
    applyStimulus(1, ga, 32'hA000 + {27'b0, ga}, 32'h4000, 4'b1111, 32'h10,
                  32'hBEEF, 32'h4004, rdy, clr);
  endtask

  task automatic idleCycle(input bit rdy);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, rdy, 0);
  endtask

  // The head must match the oldest model record every cycle, which also
  // covers stability under backpressure; a pop retires it.
  initial begin
    forever begin
      @(negedge clk);
      if (monEn && !reset) begin
        checkOutput("level", level, expQ.size());
        checkOutput("out_valid", outValid, expQ.size() != 0);
        checkOutput("drop_cnt", dropCnt, modelDrop);
        checkOutput("overflow", overflow, modelOvf);
        if (expQ.size() != 0) begin
          checkOutput("head_kind", outKind, expQ[0].kind);
          checkOutput("head_pc", outPc, expQ[0].pc);
          checkOutput("head_addr", outAddr, expQ[0].addr);
          checkOutput("head_data", outData, expQ[0].data);
          checkOutput("head_byteen", outByteen, expQ[0].byteen);
          if (outReady) void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0; failures = 0; monEn = 0;
    modelDrop = 0; modelOvf = 0;
    idleInputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", outValid, 0);
    checkOutput("reset_level", level, 0);
    checkOutput("reset_overflow", overflow, 0);
    checkOutput("reset_drop_cnt", dropCnt, 0);
    #1 reset = 0;
    @(posedge clk);
    #1;
    monEn = 1;

    $display("[TB] single GRF write");
    applyStimulus(1, 5, 32'h1234, 32'h3004, 0, 0, 0, 0, 0, 0);
    checkOutput("single_level", level, 1);
    checkOutput("single_addr", outAddr, 32'h5);
    checkOutput("single_data", outData, 32'h1234);
    idleCycle(1);

    $display("[TB] zero-register filter and dual push");
    grfEvent(0, 32'hDEAD, 0);
    checkOutput("r0_level", level, 0);
    dualEvent(3, 0, 0);
    checkOutput("dual_level", level, 2);
    checkOutput("dual_first_kind", outKind, 0);
    idleCycle(1);
    checkOutput("dual_second_kind", outKind, 1);
    idleCycle(1);

    $display("[TB] fill and overflow");
    for (int i = 0; i < 16; i++) grfEvent(5'(i + 1), 32'(i * 3), 0);
    checkOutput("fill_level", level, 16);
    grfEvent(9, 32'h77, 0);
    checkOutput("fill_drop_cnt", dropCnt, 1);
    checkOutput("fill_overflow", overflow, 1);
    checkOutput("fill_level_full", level, 16);

    $display("[TB] partial space");
    idleCycle(1);
    dualEvent(7, 0, 0);
    checkOutput("partial_level", level, 16);
    checkOutput("partial_drop_cnt", dropCnt, 2);
    idleCycle(1);
    dualEvent(8, 1, 0);
    checkOutput("partial_pop_level", level, 16);
    checkOutput("partial_pop_drop_cnt", dropCnt, 2);

    $display("[TB] backpressure and clear");
    repeat (5) idleCycle(0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("clr_overflow", overflow, 0);
    checkOutput("clr_drop_cnt", dropCnt, 0);
    dualEvent(4, 0, 1);
    checkOutput("clr_drop_overflow", overflow, 1);
    checkOutput("clr_drop_cnt_two", dropCnt, 2);

    for (int i = 0; i < 20 && expQ.size() != 0; i++) idleCycle(1);
    checkOutput("drain_level", level, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom, $urandom,
                    ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'b0000,
                    $urandom, $urandom, $urandom,
                    ($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 3 : 8)),
                    ($urandom_range(0, 29) == 0));
    end

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 20 && expQ.size() != 0; i++) idleCycle(1);
    for (int i = 0; i < 7; i++) grfEvent(5'(i + 10), 32'(i), 0);
    checkOutput("pre_reset_level", level, 7);
    #1 reset = 1;
    #1;
    checkOutput("async_reset_valid", outValid, 0);
    checkOutput("async_reset_level", level, 0);
    expQ.delete();
    modelDrop = 0;
    modelOvf  = 0;
    @(posedge clk);
    #1;
    dualEvent(6, 0, 0);
    #1 reset = 0;
    idleInputs();
    @(posedge clk);
    #1;
    checkOutput("held_reset_level", level, 0);
    checkOutput("held_reset_drop_cnt", dropCnt, 0);
    grfEvent(12, 32'h55AA, 0);
    checkOutput("post_reset_level", level, 1);
    idleCycle(1);
    idleCycle(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/commit_trace_fifo.md
COMMIT_TRACE_FIFO -- requirements
Module: commit_trace_fifo

Interface
REQ-001 Parameter DEPTH, default 16, meaning FIFO entry count; SHALL be a power of two, >= 4.
REQ-002 Parameter CNTW, default 16, meaning width of the saturating drop counter.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 w_grf_we  input  1  GRF write strobe from the CPU writeback stage.
REQ-006 w_grf_addr  input  5  GRF destination register.
REQ-007 w_grf_wdata  input  32  GRF write data.
REQ-008 w_inst_addr  input  32  PC of the writeback instruction.
REQ-009 m_data_byteen  input  4  data-memory byte enables; nonzero marks a store.
REQ-010 m_data_addr  input  32  store address.
REQ-011 m_data_wdata  input  32  store data.
REQ-012 m_inst_addr  input  32  PC of the storing instruction.
REQ-013 clr  input  1  synchronous clear of the overflow flag and drop counter.
REQ-014 out_valid  output  1  head record available.
REQ-015 out_ready  input  1  consumer accepts the head record.
REQ-016 out_kind  output  1  0 = GRF write, 1 = store.
REQ-017 out_pc  output  32  record PC.
REQ-018 out_addr  output  32  store address, or {27'b0, reg} for GRF records.
REQ-019 out_data  output  32  written data.
REQ-020 out_byteen  output  4  store byte enables; 4'b0000 for GRF records.
REQ-021 level  output  $clog2(DEPTH)+1  current occupancy.
REQ-022 overflow  output  1  sticky flag; set when any event was dropped.
REQ-023 drop_cnt  output  CNTW  saturating count of dropped events.

Function
REQ-024 A GRF event SHALL be raised in a cycle when w_grf_we=1 and w_grf_addr!=0; writes to $0 SHALL never be recorded.
REQ-025 A store event SHALL be raised in a cycle when m_data_byteen!=0.
REQ-026 Both events in one cycle SHALL be pushed in that cycle, the GRF record first (older instruction), then the store record.
REQ-027 Free space SHALL be computed as DEPTH - level + (pop this cycle ? 1 : 0); a pop and pushes in the same cycle SHALL both take effect.
REQ-028 If free space is 1 and two events occur, the GRF record SHALL be pushed and the store dropped; if free space is 0, all events that cycle SHALL be dropped.
REQ-029 Each dropped event SHALL increment drop_cnt by 1, saturating at 2^CNTW-1, and SHALL set overflow.
REQ-030 out_valid SHALL equal (level != 0); a pop SHALL occur when out_valid && out_ready.
REQ-031 Outputs out_kind..out_byteen SHALL present the head entry combinationally from storage and SHALL be held stable while out_valid=1 and out_ready=0.
REQ-032 Push-to-visible latency SHALL be 1 cycle: an event sampled at edge N is visible on out_* after edge N when the FIFO was empty.
REQ-033 Read and write pointers SHALL wrap modulo DEPTH; level SHALL range 0..DEPTH exactly.
REQ-034 clr SHALL zero overflow and drop_cnt at the next edge; a drop in the same cycle as clr SHALL leave overflow=1 and drop_cnt at 1 or 2 (the drops in that cycle).
REQ-035 When out_valid=0, out_ready SHALL be ignored.

Reset
REQ-036 While reset=1: pointers=0, level=0, out_valid=0, overflow=0, drop_cnt=0; storage contents are not reset.
REQ-037 Reset asserted mid-operation SHALL discard all queued records immediately (asynchronously).
REQ-038 Events presented while reset=1 SHALL NOT be recorded or counted.

Structure
REQ-039 Record-kind encoding, record field widths and DEPTH default SHALL live in the shared signal/constant header alongside the existing control encodings.
REQ-040 Storage SHALL be one sub-module, trace_ram: DEPTH-entry, 101-bit, two write ports, one asynchronous read port.
REQ-041 Pointer, level, drop and handshake logic SHALL reside in commit_trace_fifo.

Verification
REQ-042 Single GRF write: w_grf_we=1, addr=5, wdata=0x1234, pc=0x3004 -> next cycle out_valid=1, kind=0, addr=0x5, data=0x1234, byteen=0, level=1.
REQ-043 $0 filter plus dual push: addr=0 write -> nothing queued; then GRF(addr=3) and store(byteen=4'b1111, addr=0x10) in one cycle -> level=2, GRF record popped first.
REQ-044 Fill: 16 GRF events with out_ready=0 -> level=16; 17th event -> drop_cnt=1, overflow=1, level stays 16.
REQ-045 Partial space: level=15, dual event, no pop -> GRF pushed, store dropped, level=16, drop_cnt+1; repeat with out_ready=1 -> both pushed, level=16.
REQ-046 Backpressure: out_ready held 0 for 5 cycles -> out_* stable; assert clr -> overflow=0, drop_cnt=0 next cycle.
REQ-047 Reset mid-stream: level=7, assert reset -> out_valid=0 and level=0 without a clock edge.
